// File: rtl/s_coeff_streamer.sv
// Streams 4-bit coefficients from consecutive s_rom words, hiding the ROM read latency.
// Optional build macro S_COEFF_TWOS_EN: decode sign-magnitude nibbles to two's complement.
module s_coeff_streamer #(
  parameter int NUM_WORDS = 16,
  parameter int COEFF_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [6:0]         base_addr,
  output logic [6:0]         s_address,
  input  logic [63:0]        s_vec_64,
  output logic [COEFF_W-1:0] coeff_out,
  output logic [7:0]         coeff_idx,
  output logic               coeff_valid,
  input  logic               coeff_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRIME  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;

  logic [1:0]  state_reg;
  logic [63:0] shreg_reg;
  logic [3:0]  word_cnt_reg;
  logic [3:0]  nib_cnt_reg;
  logic [1:0]  rom_age_reg;
  logic [6:0]  addr_reg;
  logic        busy_reg;
  logic        last_word;
  logic        last_nib;
  logic        handshake;

  assign last_word = (word_cnt_reg == 4'(NUM_WORDS - 1));
  assign last_nib  = (nib_cnt_reg == 4'd15);
  // Only a pending word reload needs the prefetched data to have settled.
  assign coeff_valid = (state_reg == STREAM) &&
                       (!last_nib || last_word || rom_age_reg == 2'd2);
  assign handshake = coeff_valid && coeff_ready;

  assign s_address = addr_reg;
  assign coeff_idx = {word_cnt_reg, nib_cnt_reg};
  assign busy      = busy_reg;
  assign done      = (state_reg == FIN);

`ifdef S_COEFF_TWOS_EN
  logic [COEFF_W-1:0] mag;
  assign mag       = {1'b0, shreg_reg[COEFF_W-2:0]};
  assign coeff_out = shreg_reg[COEFF_W-1] ? (COEFF_W'(0) - mag) : mag;
`else
  assign coeff_out = shreg_reg[COEFF_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      word_cnt_reg <= '0;
      nib_cnt_reg  <= '0;
      rom_age_reg  <= '0;
      addr_reg     <= '0;
      busy_reg     <= 1'b0;
    end else begin
      // rom_age counts the cycle the address is presented as 1; data usable at 2.
      if (rom_age_reg != 2'd2) rom_age_reg <= rom_age_reg + 2'd1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg     <= base_addr;
            word_cnt_reg <= '0;
            nib_cnt_reg  <= '0;
            rom_age_reg  <= 2'd1;
            busy_reg     <= 1'b1;
            state_reg    <= PRIME;
          end
        end
        PRIME: begin
          if (rom_age_reg == 2'd2) begin
            shreg_reg   <= s_vec_64;
            nib_cnt_reg <= '0;
            addr_reg    <= addr_reg + 7'd1;
            rom_age_reg <= 2'd1;
            state_reg   <= STREAM;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (last_nib && last_word) begin
              state_reg <= FIN;
            end else if (last_nib) begin
              shreg_reg    <= s_vec_64;
              word_cnt_reg <= word_cnt_reg + 4'd1;
              nib_cnt_reg  <= '0;
              addr_reg     <= addr_reg + 7'd1;
              rom_age_reg  <= 2'd1;
            end else begin
              shreg_reg   <= shreg_reg >> COEFF_W;
              nib_cnt_reg <= nib_cnt_reg + 4'd1;
            end
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_coeff_streamer.sv
// Directed bench for s_coeff_streamer with a registered-read ROM model.
module tb_s_coeff_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  base_addr = '0;
  logic [6:0]  s_address;
  logic [63:0] s_vec_64 = '0;
  logic [3:0]  coeff_out;
  logic [7:0]  coeff_idx;
  logic        coeff_valid;
  logic        coeff_ready = 1'b0;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef S_COEFF_TWOS_EN
  localparam logic [3:0] EXP_B = 4'hD;
  localparam logic [3:0] EXP_A = 4'hE;
`else
  localparam logic [3:0] EXP_B = 4'hB;
  localparam logic [3:0] EXP_A = 4'hA;
`endif

  logic [63:0] rom [128];

  s_coeff_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .s_address(s_address), .s_vec_64(s_vec_64), .coeff_out(coeff_out),
    .coeff_idx(coeff_idx), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) s_vec_64 <= rom[s_address];

  function automatic logic [3:0] dec(input logic [3:0] n);
`ifdef S_COEFF_TWOS_EN
    logic [3:0] m;
    m = {1'b0, n[2:0]};
    return n[3] ? (4'd0 - m) : m;
`else
    return n;
`endif
  endfunction

  function automatic logic [3:0] exp_coeff(input int base, input int k);
    logic [63:0] w;
    w = rom[(base + k / 16) % 128] >> (4 * (k % 16));
    return dec(w[3:0]);
  endfunction

  // Capture results
  logic [3:0] got_out[$];
  logic [7:0] got_idx[$];
  logic [6:0] addr_seq[$];
  int hs_cnt, first_valid, last_hs, done_at, hold_err, valid_cnt;
  bit timed_out;

  // mode 0: ready high, 1: random ready, 2: stall 10 cycles at idx 15
  task automatic capture(input logic [6:0] base, input int mode, input int inject_at);
    int n, stall_cnt;
    bit prev_stall, r;
    logic [3:0] prev_out;
    logic [7:0] prev_idx;
    got_out.delete(); got_idx.delete(); addr_seq.delete();
    hs_cnt = 0; first_valid = -1; last_hs = -1; done_at = -1;
    hold_err = 0; valid_cnt = 0; timed_out = 0;
    stall_cnt = 0; prev_stall = 0; prev_out = '0; prev_idx = '0;
    @(negedge clk); base_addr = base; start = 1'b1; coeff_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    n = 1;
    forever begin
      if (addr_seq.size() == 0 || addr_seq[$] != s_address) addr_seq.push_back(s_address);
      if (prev_stall && (!coeff_valid || coeff_out !== prev_out || coeff_idx !== prev_idx))
        hold_err++;
      if (done) begin done_at = n; break; end
      if (coeff_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = n;
      end
      case (mode)
        0: r = 1'b1;
        1: r = 1'($urandom % 2);
        default: begin
          r = 1'b1;
          if (coeff_valid && coeff_idx == 8'd15 && stall_cnt < 10) begin
            r = 1'b0;
            stall_cnt++;
          end
        end
      endcase
      coeff_ready = r;
      if (coeff_valid && r) begin
        got_out.push_back(coeff_out);
        got_idx.push_back(coeff_idx);
        hs_cnt++;
        last_hs = n;
      end
      prev_stall = coeff_valid && !r;
      prev_out = coeff_out;
      prev_idx = coeff_idx;
      if (n == inject_at) begin start = 1'b1; base_addr = 7'd5; end
      else start = 1'b0;
      @(negedge clk);
      n++;
      if (n > 3000) begin timed_out = 1; break; end
    end
    start = 1'b0;
    coeff_ready = 1'b0;
    while (got_out.size() < 256) begin got_out.push_back(4'hx); got_idx.push_back(8'hxx); end
  endtask

  // Counts mismatches of the captured stream against the ROM image
  function automatic int seq_errors(input int base);
    int e = 0;
    for (int k = 0; k < 256; k++)
      if (got_out[k] !== exp_coeff(base, k) || got_idx[k] !== 8'(k)) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt += 6;
    if (s_address !== 7'd0) $display("FAIL reset_addr got=%0d want=0", s_address); else pass_cnt++;
    if (coeff_out !== 4'd0) $display("FAIL reset_coeff got=%h want=0", coeff_out); else pass_cnt++;
    if (coeff_idx !== 8'd0) $display("FAIL reset_idx got=%0d want=0", coeff_idx); else pass_cnt++;
    if (coeff_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", coeff_valid); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass_cnt++;
    rst = 1'b0;
    $display("reset: addr=%0d valid=%b busy=%b done=%b", s_address, coeff_valid, busy, done);
  endtask

  task automatic test_full_rate();
    int e;
    capture(7'd0, 0, -1);
    e = seq_errors(0);
    total_cnt += 13;
    if (timed_out) $display("FAIL full_timeout got=timeout want=done"); else pass_cnt++;
    if (got_out[0] !== 4'h3) $display("FAIL full_idx0 got=%h want=3", got_out[0]); else pass_cnt++;
    if (got_out[1] !== 4'h3) $display("FAIL full_idx1 got=%h want=3", got_out[1]); else pass_cnt++;
    if (got_out[2] !== EXP_B) $display("FAIL full_idx2 got=%h want=%h", got_out[2], EXP_B); else pass_cnt++;
    if (got_out[15] !== EXP_A) $display("FAIL full_idx15 got=%h want=%h", got_out[15], EXP_A); else pass_cnt++;
    if (got_out[240] !== 4'h3) $display("FAIL full_idx240 got=%h want=3", got_out[240]); else pass_cnt++;
    if (got_out[255] !== EXP_A) $display("FAIL full_idx255 got=%h want=%h", got_out[255], EXP_A); else pass_cnt++;
    if (e != 0) $display("FAIL full_seq got=%0d_errors want=0", e); else pass_cnt++;
    if (first_valid != 3) $display("FAIL full_first_valid got=%0d want=3", first_valid); else pass_cnt++;
    if (valid_cnt != 256) $display("FAIL full_valid_cnt got=%0d want=256", valid_cnt); else pass_cnt++;
    if (last_hs != 258) $display("FAIL full_last_hs got=%0d want=258", last_hs); else pass_cnt++;
    if (done_at != 259) $display("FAIL full_done_at got=%0d want=259", done_at); else pass_cnt++;
    if (busy !== 1'b1) $display("FAIL full_busy_at_done got=%b want=1", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL full_busy_after got=%b want=0", busy); else pass_cnt++;
    $display("full_rate: hs=%0d first=%0d done_at=%0d seq_err=%0d", hs_cnt, first_valid, done_at, e);
  endtask

  task automatic test_backpressure();
    int e;
    capture(7'd0, 1, -1);
    e = seq_errors(0);
    total_cnt += 4;
    if (timed_out) $display("FAIL bp_timeout got=timeout want=done"); else pass_cnt++;
    if (hs_cnt != 256) $display("FAIL bp_hs_cnt got=%0d want=256", hs_cnt); else pass_cnt++;
    if (e != 0) $display("FAIL bp_seq got=%0d_errors want=0", e); else pass_cnt++;
    if (hold_err != 0) $display("FAIL bp_hold got=%0d_changes want=0", hold_err); else pass_cnt++;
    $display("backpressure: hs=%0d done_at=%0d seq_err=%0d hold_err=%0d", hs_cnt, done_at, e, hold_err);
  endtask

  task automatic test_word_boundary_stall();
    int e;
    capture(7'd0, 2, -1);
    e = seq_errors(0);
    total_cnt += 5;
    if (got_idx[16] !== 8'd16) $display("FAIL wb_idx16 got=%0d want=16", got_idx[16]); else pass_cnt++;
    if (got_out[16] !== 4'h1) $display("FAIL wb_coeff16 got=%h want=1", got_out[16]); else pass_cnt++;
    if (hold_err != 0) $display("FAIL wb_hold got=%0d_changes want=0", hold_err); else pass_cnt++;
    if (e != 0) $display("FAIL wb_seq got=%0d_errors want=0", e); else pass_cnt++;
    if (done_at != 269) $display("FAIL wb_done_at got=%0d want=269", done_at); else pass_cnt++;
    $display("word_boundary_stall: idx16=%0d coeff16=%h done_at=%0d", got_idx[16], got_out[16], done_at);
  endtask

  task automatic test_reset_mid_stream();
    int n, e;
    @(negedge clk); base_addr = 7'd0; start = 1'b1; coeff_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(coeff_valid && coeff_idx == 8'd100) && n < 500) begin @(negedge clk); n++; end
    total_cnt++;
    if (n >= 500) $display("FAIL rm_reach100 got=timeout want=idx100"); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt += 3;
    if (coeff_valid !== 1'b0) $display("FAIL rm_valid got=%b want=0", coeff_valid); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rm_busy got=%b want=0", busy); else pass_cnt++;
    if (s_address !== 7'd0) $display("FAIL rm_addr got=%0d want=0", s_address); else pass_cnt++;
    rst = 1'b0;
    coeff_ready = 1'b0;
    capture(7'd0, 0, -1);
    e = seq_errors(0);
    total_cnt += 3;
    if (got_idx[0] !== 8'd0) $display("FAIL rm_restart_idx got=%0d want=0", got_idx[0]); else pass_cnt++;
    if (hs_cnt != 256) $display("FAIL rm_hs_cnt got=%0d want=256", hs_cnt); else pass_cnt++;
    if (e != 0) $display("FAIL rm_seq got=%0d_errors want=0", e); else pass_cnt++;
    $display("reset_mid_stream: restart idx0=%0d hs=%0d seq_err=%0d", got_idx[0], hs_cnt, e);
  endtask

  task automatic test_start_while_busy();
    int e;
    capture(7'd0, 0, 50);
    e = seq_errors(0);
    total_cnt += 3;
    if (hs_cnt != 256) $display("FAIL sb_hs_cnt got=%0d want=256", hs_cnt); else pass_cnt++;
    if (e != 0) $display("FAIL sb_seq got=%0d_errors want=0", e); else pass_cnt++;
    if (done_at != 259) $display("FAIL sb_done_at got=%0d want=259", done_at); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL sb_no_restart got=%b want=0", busy); else pass_cnt++;
    $display("start_while_busy: hs=%0d done_at=%0d seq_err=%0d", hs_cnt, done_at, e);
  endtask

  task automatic test_addr_wrap();
    int e, ae;
    capture(7'd120, 0, -1);
    e = seq_errors(120);
    ae = 0;
    for (int k = 0; k < 16; k++)
      if (k >= addr_seq.size() || addr_seq[k] !== 7'((120 + k) % 128)) ae++;
    total_cnt += 3;
    if (ae != 0) $display("FAIL wrap_addr_seq got=%0d_errors want=0", ae); else pass_cnt++;
    if (e != 0) $display("FAIL wrap_seq got=%0d_errors want=0", e); else pass_cnt++;
    if (hs_cnt != 256) $display("FAIL wrap_hs_cnt got=%0d want=256", hs_cnt); else pass_cnt++;
    $display("addr_wrap: addr_err=%0d seq_err=%0d hs=%0d", ae, e, hs_cnt);
  endtask

  initial begin
    for (int i = 0; i < 128; i++)
      rom[i] = 64'h0F1E2D3C4B5A6978 ^ {8{8'(i * 37 + 11)}};
    rom[0]  = 64'hA1993232A39BBB33;
    rom[1]  = 64'h00193230020A21B1;
    rom[15] = 64'hA000000000000003;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_word_boundary_stall();
    test_reset_mid_stream();
    test_start_while_busy();
    test_addr_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
